// File: rtl/unidad_con_param.sv
// unidad_con_param: handshaked control unit sequencing bus enables and load strobes for the accumulator datapath.
module unidad_con_param #(
  parameter int HOLD_CYC = 1,
  parameter int STRB_CYC = 1,
  parameter int N_REG    = 2,
  parameter int SEL_W    = 1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [2:0]       instruction,
  input  logic [SEL_W-1:0] reg_sel,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic             oe_memo,
  output logic             oe_alu,
  output logic             oe_port,
  output logic             r_w,
  output logic             clk1,
  output logic             clk2,
  output logic [N_REG-1:0] clk_reg
);
  localparam int MX = HOLD_CYC > STRB_CYC ? HOLD_CYC : STRB_CYC;
  localparam int CW = $clog2(MX) + 1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RELEASE} state_t;
  state_t           r_state, w_nxt;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic [2:0]       r_op, w_op;
  logic [SEL_W-1:0] r_sel, w_sel;
  logic             w_ill, w_acc, w_act, w_stb;
  always_comb begin
    w_ill = instruction == 3'b101 || (instruction == 3'b111 && 32'(reg_sel) >= N_REG);
    w_acc = r_state == IDLE && start && !w_ill;
    w_nxt = r_state;
    w_cnt = r_cnt;
    w_op  = r_op;
    w_sel = r_sel;
    case (r_state)
      IDLE: if (w_acc) begin
        w_nxt = SETUP;
        w_cnt = CW'(HOLD_CYC - 1);
        w_op  = instruction;
        w_sel = reg_sel;
      end
      SETUP: begin
        w_nxt = r_cnt == '0 ? STROBE : SETUP;
        w_cnt = r_cnt == '0 ? CW'(STRB_CYC - 1) : r_cnt - CW'(1);
      end
      STROBE: begin
        w_nxt = r_cnt == '0 ? RELEASE : STROBE;
        w_cnt = r_cnt == '0 ? '0 : r_cnt - CW'(1);
      end
      default: begin
        w_nxt = IDLE;
        w_cnt = '0;
      end
    endcase
    w_act = w_nxt != IDLE;
    w_stb = w_nxt == STROBE;
  end
  // outputs are decoded from the next state so they are registered yet valid right after the accepting edge
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_sel   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      oe_memo <= 1'b0;
      oe_alu  <= 1'b0;
      oe_port <= 1'b1;
      r_w     <= 1'b0;
      clk1    <= 1'b0;
      clk2    <= 1'b0;
      clk_reg <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_op    <= w_op;
      r_sel   <= w_sel;
      busy    <= w_act;
      done    <= w_nxt == RELEASE;
      illegal <= r_state == IDLE && start && w_ill;
      oe_memo <= w_act && w_op[2:1] == 2'b01;
      oe_alu  <= w_act && (w_op[2:1] == 2'b00 || w_op == 3'b111 || w_op == 3'b100);
      oe_port <= !(w_act && w_op == 3'b110);
      r_w     <= w_stb && w_op == 3'b100;
      clk1    <= w_stb && (w_op == 3'b011 || w_op == 3'b001);
      clk2    <= w_stb && (w_op == 3'b010 || w_op == 3'b000 || w_op == 3'b110);
      clk_reg <= (w_stb && w_op == 3'b111) ? N_REG'(1) << w_sel : '0;
    end
  end
endmodule

// File: tb/tb_unidad_con_param.sv
// tb_unidad_con_param: table-driven check of three parameterisations of the control unit.
module tb_unidad_con_param;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       clear_n, start;
  logic [2:0] instruction;
  logic [1:0] reg_sel;
  logic [2:0] busy, done, ill, memo, alu, port, rw, c1, c2;
  logic [1:0] creg0, creg2;
  logic [3:0] creg1;
  logic [12:0] ov [3];
  assign ov[0] = {busy[0], done[0], ill[0], memo[0], alu[0], port[0], rw[0], c1[0], c2[0], 2'b00, creg0};
  assign ov[1] = {busy[1], done[1], ill[1], memo[1], alu[1], port[1], rw[1], c1[1], c2[1], creg1};
  assign ov[2] = {busy[2], done[2], ill[2], memo[2], alu[2], port[2], rw[2], c1[2], c2[2], 2'b00, creg2};

  unidad_con_param u0 (
    .clk(clk), .clear_n(clear_n), .start(start), .instruction(instruction), .reg_sel(reg_sel[0]),
    .busy(busy[0]), .done(done[0]), .illegal(ill[0]), .oe_memo(memo[0]), .oe_alu(alu[0]),
    .oe_port(port[0]), .r_w(rw[0]), .clk1(c1[0]), .clk2(c2[0]), .clk_reg(creg0));
  unidad_con_param #(.HOLD_CYC(2), .STRB_CYC(3), .N_REG(4), .SEL_W(2)) u1 (
    .clk(clk), .clear_n(clear_n), .start(start), .instruction(instruction), .reg_sel(reg_sel),
    .busy(busy[1]), .done(done[1]), .illegal(ill[1]), .oe_memo(memo[1]), .oe_alu(alu[1]),
    .oe_port(port[1]), .r_w(rw[1]), .clk1(c1[1]), .clk2(c2[1]), .clk_reg(creg1));
  unidad_con_param #(.HOLD_CYC(1), .STRB_CYC(3), .N_REG(2), .SEL_W(2)) u2 (
    .clk(clk), .clear_n(clear_n), .start(start), .instruction(instruction), .reg_sel(reg_sel),
    .busy(busy[2]), .done(done[2]), .illegal(ill[2]), .oe_memo(memo[2]), .oe_alu(alu[2]),
    .oe_port(port[2]), .r_w(rw[2]), .clk1(c1[2]), .clk2(c2[2]), .clk_reg(creg2));

  typedef struct {
    logic        rn;
    logic        st;
    logic [2:0]  ins;
    logic [1:0]  sel;
    int          d;
    logic [12:0] exp;
  } vec_t;
  vec_t v[$];
  int n_chk = 0, n_fail = 0;

  function automatic logic [12:0] e(input logic b, dn, il, m, a, p, w, k1, k2, input logic [3:0] cr);
    return {b, dn, il, m, a, p, w, k1, k2, cr};
  endfunction
  task automatic add(input logic rn, st, input logic [2:0] ins, input logic [1:0] sel, input int d, input logic [12:0] x);
    v.push_back('{rn, st, ins, sel, d, x});
  endtask

  initial begin
    logic [12:0] idl;
    logic [4:0]  bx;
    idl = e(0,0,0,0,0,1,0,0,0,4'b0000);
    clear_n = 1'b0; start = 1'b0; instruction = 3'b000; reg_sel = 2'b00;
    // reset defaults on every instance
    add(0,1,3'b011,0,0,idl); add(0,1,3'b011,0,1,idl); add(0,1,3'b011,0,2,idl);
    add(1,0,3'b000,0,0,idl); add(1,0,3'b000,0,1,idl);
    // defaults: 011 memory -> A
    add(1,1,3'b011,0,0,e(1,0,0,1,0,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,0,e(1,0,0,1,0,1,0,1,0,4'b0000));
    add(1,0,3'b000,0,0,e(1,1,0,1,0,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,0,idl);
    add(0,0,3'b000,0,1,idl);
    // H2/S3/N4: 111 to output register 2
    add(1,1,3'b111,2,1,e(1,0,0,0,1,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,1,e(1,0,0,0,1,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,1,e(1,0,0,0,1,1,0,0,0,4'b0100));
    add(1,0,3'b000,0,1,e(1,0,0,0,1,1,0,0,0,4'b0100));
    add(1,0,3'b000,0,1,e(1,0,0,0,1,1,0,0,0,4'b0100));
    add(1,0,3'b000,0,1,e(1,1,0,0,1,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,1,idl);
    add(0,0,3'b000,0,2,idl);
    // illegal requests on N_REG=2, SEL_W=2
    add(1,1,3'b101,0,2,e(0,0,1,0,0,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,2,idl);
    add(1,1,3'b111,3,2,e(0,0,1,0,0,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,2,idl);
    add(0,0,3'b000,0,0,idl);
    // 110 with a 000 start while busy, then 100 memory write
    add(1,1,3'b110,0,0,e(1,0,0,0,0,0,0,0,0,4'b0000));
    add(1,1,3'b000,0,0,e(1,0,0,0,0,0,0,0,1,4'b0000));
    add(1,1,3'b000,0,0,e(1,1,0,0,0,0,0,0,0,4'b0000));
    add(1,0,3'b000,0,0,idl);
    add(1,1,3'b100,0,0,e(1,0,0,0,1,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,0,e(1,0,0,0,1,1,1,0,0,4'b0000));
    add(1,0,3'b000,0,0,e(1,1,0,0,1,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,0,idl);
    add(0,0,3'b000,0,2,idl);
    // reset while clk1 is high with STRB_CYC=3, then a clean rerun
    add(1,1,3'b011,0,2,e(1,0,0,1,0,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,2,e(1,0,0,1,0,1,0,1,0,4'b0000));
    add(0,0,3'b000,0,2,idl);
    add(1,0,3'b000,0,2,idl);
    add(1,1,3'b011,0,2,e(1,0,0,1,0,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,2,e(1,0,0,1,0,1,0,1,0,4'b0000));
    add(1,0,3'b000,0,2,e(1,0,0,1,0,1,0,1,0,4'b0000));
    add(1,0,3'b000,0,2,e(1,0,0,1,0,1,0,1,0,4'b0000));
    add(1,0,3'b000,0,2,e(1,1,0,1,0,1,0,0,0,4'b0000));
    add(1,0,3'b000,0,2,idl);
    add(0,0,3'b000,0,0,idl);
    for (int i = 0; i < v.size(); i++) begin
      clear_n = v[i].rn; start = v[i].st; instruction = v[i].ins; reg_sel = v[i].sel;
      @(posedge clk); #1;
      n_chk++;
      if (ov[v[i].d] !== v[i].exp) begin
        n_fail++;
        $display("FAIL row%0d dut%0d: got %b, want %b", i, v[i].d, ov[v[i].d], v[i].exp);
      end
    end
    // start held high: re-accepted only once back in IDLE
    bx = 5'b10111;
    clear_n = 1'b1; start = 1'b1; instruction = 3'b011; reg_sel = 2'b00;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if (busy[0] !== bx[k]) begin
        n_fail++;
        $display("FAIL b2b_busy k%0d: got %b, want %b", k, busy[0], bx[k]);
      end
      n_chk++;
      if (done[0] !== (k == 2)) begin
        n_fail++;
        $display("FAIL b2b_done k%0d: got %b, want %b", k, done[0], k == 2);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/unidad_con_param.md
Name: unidad_con_param

Overview:
- Parametrised successor to the 3-state control unit for the accumulator datapath.
- Adds a start/busy/done handshake, configurable setup and strobe lengths, a vector of N_REG register-load strobes, a memory-write opcode, and illegal-opcode flagging.
- Sits between the instruction source and the datapath. Drives bus output enables (memory, ALU, port), memory r_w, and the load strobes of register A, register B and the output registers.
- All outputs are registered and glitch-free; there are no combinational paths from inputs to outputs.

Parameters:
- HOLD_CYC, 1: cycles enables are driven before the strobe rises (bus setup); must be >=1.
- STRB_CYC, 1: cycles the load/write strobe stays high; must be >=1.
- N_REG, 2: number of output registers, i.e. width of clk_reg; must be >=1.
- SEL_W, 1: width of reg_sel; must satisfy 2**SEL_W >= N_REG.

Ports:
- clk  in  1  system clock, all logic on the rising edge
- clear_n  in  1  synchronous active-low reset
- start  in  1  instruction valid; accepted only when busy=0
- instruction  in  3  opcode, sampled with start
- reg_sel  in  SEL_W  output-register index for opcode 111, sampled with start
- busy  out  1  high from the accept edge until return to IDLE
- done  out  1  one-cycle pulse in the RELEASE cycle
- illegal  out  1  one-cycle pulse: rejected instruction
- oe_memo  out  1  memory drives bus
- oe_alu  out  1  ALU drives bus
- oe_port  out  1  port enable, active-low (0 = input port drives bus)
- r_w  out  1  1 = memory write
- clk1  out  1  register A load strobe
- clk2  out  1  register B load strobe
- clk_reg  out  N_REG  output-register load strobes, one-hot or zero

Behaviour:
- Reset (clear_n=0 at an edge): state IDLE, counters 0. Outputs: oe_port=1; every other output 0, including busy, done, illegal, strobes and clk_reg.
- Reset dominates start and aborts any operation in flight; strobes fall at that same edge.
- Idle output values, also used in every non-active state: oe_port=1, all other outputs 0.
- States: IDLE, SETUP, STROBE, RELEASE.
- IDLE:
  - start=1 with a legal request: latch instruction and reg_sel, go to SETUP, busy=1.
  - start=1 with an illegal request: illegal=1 for the next cycle only, stay in IDLE, busy stays 0.
- Illegal requests: opcode 101, or opcode 111 with reg_sel >= N_REG.
- start is ignored while busy=1; the latched opcode is unaffected by input changes.
- SETUP, HOLD_CYC cycles: enables per the opcode table; all strobes 0; r_w=0.
- STROBE, STRB_CYC cycles: same enables; the opcode's strobe is high for exactly STRB_CYC cycles.
- RELEASE, 1 cycle: strobes 0, enables still held (bus hold time), done=1. Next edge returns to IDLE with idle outputs and busy=0.
- Opcode table (enables held in SETUP, STROBE and RELEASE; strobe active in STROBE):
  - 011: oe_memo=1, strobe clk1 (memory -> A)
  - 010: oe_memo=1, strobe clk2 (memory -> B)
  - 001: oe_alu=1, strobe clk1 (ALU -> A)
  - 000: oe_alu=1, strobe clk2 (ALU -> B)
  - 111: oe_alu=1, strobe clk_reg[reg_sel] (ALU -> output register)
  - 110: oe_port=0, strobe clk2 (port -> B)
  - 100: oe_alu=1; r_w=1 only during STROBE (memory write); no load strobe
- Invariants:
  - At most one of oe_memo, oe_alu, or (oe_port=0) is active in any cycle.
  - At most one strobe bit is high in any cycle.
  - Strobes never rise in the same cycle an enable changes.
- Latency: start sampled at edge k. SETUP outputs are valid after edge k; the strobe rises after edge k+HOLD_CYC; done is high after edge k+HOLD_CYC+STRB_CYC; busy=0 after edge k+HOLD_CYC+STRB_CYC+1.
- Throughput: one instruction per HOLD_CYC+STRB_CYC+2 cycles, since start is accepted only in IDLE.
- Counter: one shared down-counter of width clog2(max(HOLD_CYC,STRB_CYC))+1. It is reloaded on state entry, with no wrap beyond the terminal count.

Test Plan:
- Reset, defaults: clear_n=0 for 2 cycles, then 1 -> oe_port=1, all else 0, busy=0.
- Defaults, start with 011 at edge 0 -> oe_memo=1 after edges 0..2; clk1=1 only after edge 1; done=1 only after edge 2; busy=0 after edge 3; clk2 and clk_reg stay 0.
- HOLD_CYC=2, STRB_CYC=3, N_REG=4, SEL_W=2, start with 111 and reg_sel=2 -> clk_reg=4'b0100 for exactly 3 cycles after 2 setup cycles, oe_alu=1 for 6 cycles, done pulses once.
- Illegal requests: start with 101, then 111 with reg_sel=3 under N_REG=2 -> illegal pulses one cycle each; busy, strobes and enables stay at idle values.
- Start while busy, and opcode 100: assert start with 000 during an active 110 -> ignored; 110 completes with oe_port=0 and a clk2 pulse. Then 100 -> oe_alu=1 and r_w=1 only in the STROBE cycle.
- Reset mid-strobe: clear_n=0 while clk1=1 (STRB_CYC=3) -> clk1=0 and idle outputs after that edge; no done pulse; the next start runs normally.
